// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the EX-stage branch resolution slice.
//   br_op_e     : encoding of the ex_br_op field
//   ctr_weak_nt : reset value of a predictor counter (weakly-not-taken)
package branch_resolve_unit_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_JAL  = 3'd5,
    BR_JR   = 3'd6,
    BR_RSVD = 3'd7
  } br_op_e;

  // Weakly-not-taken: 2^(bits-1)-1
  function automatic int unsigned ctr_weak_nt(input int unsigned bits);
    return (32'd1 << (bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up/down counter with enable.
//   clk, rst_n : clock, async active-low reset (loads RST_VAL)
//   en_i       : counter may change this cycle
//   inc_i      : count up (priority over dec_i), stops at all-ones
//   dec_i      : count down, stops at zero
//   cnt_o      : current count
module sat_counter #(
  parameter int unsigned     W       = 2,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (inc_i) begin
        if (cnt_q != '1) cnt_d = cnt_q + W'(1);
      end else if (dec_i) begin
        if (cnt_q != '0) cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= RST_VAL;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: target computation, condition evaluation,
// predictor table (read by IF), one-cycle registered redirect/flush and
// saturating performance counters.
//   if_pc / if_pred_taken        : IF-side predictor lookup
//   ex_*                         : instruction being resolved in EX
//   redirect_valid/redirect_pc   : registered one-cycle redirect to IF
//   flush                        : same as redirect_valid, squashes IF/ID
//   branch_cnt / mispred_cnt     : saturating statistics
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned SHAMT     = 2,
  parameter int unsigned BHT_DEPTH = 16,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic [2:0]        ex_br_op,
  input  logic [XLEN-1:0]   ex_pc_plus4,
  input  logic [XLEN-1:0]   ex_imm,
  input  logic [XLEN-1:0]   ex_rs_a,
  input  logic [XLEN-1:0]   ex_rs_b,
  input  logic              ex_pred_taken,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              flush,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int unsigned           IDX_W   = $clog2(BHT_DEPTH);
  localparam logic [CTR_BITS-1:0]   CTR_RST = CTR_BITS'(ctr_weak_nt(CTR_BITS));
  localparam logic [XLEN-1:0]       JR_MASK = ~((XLEN'(1) << SHAMT) - XLEN'(1));

  br_op_e                          op;
  logic                            is_cond;
  logic                            resolve;
  logic                            taken;
  logic                            mispred;
  logic [XLEN-1:0]                 target;
  logic [XLEN-1:0]                 actual_pc;
  logic [XLEN-1:0]                 upd_pc;
  logic [IDX_W-1:0]                lk_idx;
  logic [IDX_W-1:0]                upd_idx;
  logic [BHT_DEPTH-1:0][CTR_BITS-1:0] bht_q;

  logic                            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]                 redirect_pc_q, redirect_pc_d;

  assign op = br_op_e'(ex_br_op);

  // Anything arriving while a redirect is out is wrong-path and ignored.
  assign resolve = ex_valid && !ex_stall && !redirect_valid_q &&
                   (op != BR_NONE) && (op != BR_RSVD);

  always_comb begin
    is_cond = 1'b0;
    taken   = 1'b0;
    target  = ex_pc_plus4 + (ex_imm << SHAMT);
    case (op)
      BR_BEQ: begin is_cond = 1'b1; taken = (ex_rs_a == ex_rs_b); end
      BR_BNE: begin is_cond = 1'b1; taken = (ex_rs_a != ex_rs_b); end
      BR_BLT: begin is_cond = 1'b1; taken = ($signed(ex_rs_a) <  $signed(ex_rs_b)); end
      BR_BGE: begin is_cond = 1'b1; taken = ($signed(ex_rs_a) >= $signed(ex_rs_b)); end
      BR_JAL: taken = 1'b1;
      BR_JR: begin
        taken  = 1'b1;
        target = ex_rs_a & JR_MASK;
      end
      default: ;
    endcase
  end

  assign actual_pc = taken ? target : ex_pc_plus4;
  // JR has no predicted target, so it always redirects.
  assign mispred   = (op == BR_JR) ? 1'b1 : (taken != ex_pred_taken);

  // Redirect register
  always_comb begin
    redirect_valid_d = resolve && mispred;
    redirect_pc_d    = redirect_pc_q;
    if (resolve && mispred) redirect_pc_d = actual_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign flush          = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

  // Predictor table
  assign upd_pc  = ex_pc_plus4 - XLEN'(4);
  assign lk_idx  = if_pc[SHAMT+IDX_W-1:SHAMT];
  assign upd_idx = upd_pc[SHAMT+IDX_W-1:SHAMT];

  for (genvar g = 0; g < BHT_DEPTH; g++) begin : g_bht
    sat_counter #(
      .W       (CTR_BITS),
      .RST_VAL (CTR_RST)
    ) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (resolve && is_cond && (upd_idx == IDX_W'(g))),
      .inc_i (taken),
      .dec_i (!taken),
      .cnt_o (bht_q[g])
    );
  end

  assign if_pred_taken = bht_q[lk_idx][CTR_BITS-1];

  // Performance counters
  sat_counter #(
    .W       (STAT_W),
    .RST_VAL ('0)
  ) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (resolve),
    .inc_i (1'b1),
    .dec_i (1'b0),
    .cnt_o (branch_cnt)
  );

  sat_counter #(
    .W       (STAT_W),
    .RST_VAL ('0)
  ) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (resolve && mispred),
    .inc_i (1'b1),
    .dec_i (1'b0),
    .cnt_o (mispred_cnt)
  );

  // Only the index bits of the PCs are used.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc, upd_pc};

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic        ex_stall;
  logic [2:0]  ex_br_op;
  logic [31:0] ex_pc_plus4;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs_a;
  logic [31:0] ex_rs_b;
  logic        ex_pred_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] branch_cnt;
  logic [15:0] mispred_cnt;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(
    .XLEN      (32),
    .SHAMT     (2),
    .BHT_DEPTH (16),
    .CTR_BITS  (2),
    .STAT_W    (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_br_op       (ex_br_op),
    .ex_pc_plus4    (ex_pc_plus4),
    .ex_imm         (ex_imm),
    .ex_rs_a        (ex_rs_a),
    .ex_rs_b        (ex_rs_b),
    .ex_pred_taken  (ex_pred_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] op, input logic [31:0] pc4, input logic [31:0] imm,
                         input logic [31:0] a, input logic [31:0] b, input logic pred);
    ex_valid      = 1'b1;
    ex_br_op      = op;
    ex_pc_plus4   = pc4;
    ex_imm        = imm;
    ex_rs_a       = a;
    ex_rs_b       = b;
    ex_pred_taken = pred;
  endtask

  initial begin
    rst_n = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_stall = 1'b0; ex_br_op = '0;
    ex_pc_plus4 = '0; ex_imm = '0; ex_rs_a = '0; ex_rs_b = '0; ex_pred_taken = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset state
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_flush",          32'(flush),          32'd0);
    check("rst_redirect_pc",    redirect_pc,         32'd0);
    check("rst_branch_cnt",     32'(branch_cnt),     32'd0);
    check("rst_mispred_cnt",    32'(mispred_cnt),    32'd0);
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'(i) << 2;
      #1;
      check($sformatf("rst_pred_idx%0d", i), 32'(if_pred_taken), 32'd0);
    end

    // BEQ correctly predicted not-taken, PC 0x100 -> index 0
    if_pc = 32'h100;
    present(3'd1, 32'h104, 32'd3, 32'd5, 32'd6, 1'b0);
    step();
    ex_valid = 1'b0;
    check("beq_redirect",    32'(redirect_valid), 32'd0);
    check("beq_branch_cnt",  32'(branch_cnt),     32'd1);
    check("beq_mispred_cnt", 32'(mispred_cnt),    32'd0);
    check("beq_bht0",        32'(dut.bht_q[0]),   32'd0);

    // BNE mispredicted taken: 0x104 + (-2<<2) = 0xFC
    present(3'd2, 32'h104, 32'hFFFF_FFFE, 32'd1, 32'd2, 1'b0);
    step();
    // wrong-path instruction during the redirect cycle (would mispredict)
    present(3'd1, 32'h104, 32'd0, 32'd7, 32'd7, 1'b0);
    check("bne_redirect_valid", 32'(redirect_valid), 32'd1);
    check("bne_flush",          32'(flush),          32'd1);
    check("bne_redirect_pc",    redirect_pc,         32'h0000_00FC);
    check("bne_branch_cnt",     32'(branch_cnt),     32'd2);
    check("bne_mispred_cnt",    32'(mispred_cnt),    32'd1);
    step();
    ex_valid = 1'b0;
    check("bne_pulse_end",       32'(redirect_valid), 32'd0);
    check("squash_branch_cnt",   32'(branch_cnt),     32'd2);
    check("squash_mispred_cnt",  32'(mispred_cnt),    32'd1);
    check("bne_bht0",            32'(dut.bht_q[0]),   32'd1);

    // JR: target 0x2003 with low two bits cleared
    present(3'd6, 32'h144, 32'd0, 32'h2003, 32'd0, 1'b1);
    step();
    ex_valid = 1'b0;
    check("jr_redirect_valid", 32'(redirect_valid), 32'd1);
    check("jr_redirect_pc",    redirect_pc,         32'h0000_2000);
    check("jr_branch_cnt",     32'(branch_cnt),     32'd3);
    check("jr_mispred_cnt",    32'(mispred_cnt),    32'd2);
    check("jr_bht0",           32'(dut.bht_q[0]),   32'd1);
    step();
    check("jr_pulse_end",      32'(redirect_valid), 32'd0);

    // Four taken BLT at PC 0x104 (index 1), predicted taken -> no redirects
    if_pc = 32'h104;
    present(3'd3, 32'h108, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1);
    #1;
    check("blt_lookup_old", 32'(if_pred_taken), 32'd0);
    step();
    check("blt1_bht1",  32'(dut.bht_q[1]),   32'd2);
    check("blt1_pred",  32'(if_pred_taken),  32'd1);
    step();
    check("blt2_bht1",  32'(dut.bht_q[1]),   32'd3);
    step();
    check("blt3_bht1",  32'(dut.bht_q[1]),   32'd3);
    step();
    ex_valid = 1'b0;
    check("blt4_bht1",     32'(dut.bht_q[1]),   32'd3);
    check("blt4_pred",     32'(if_pred_taken),  32'd1);
    check("blt_redirect",  32'(redirect_valid), 32'd0);
    check("blt_branch_cnt",  32'(branch_cnt),   32'd7);
    check("blt_mispred_cnt", 32'(mispred_cnt),  32'd2);

    // BGE -2 >= 1 is false (signed); predicted taken -> redirect to pc+4
    present(3'd4, 32'h110, 32'd8, 32'hFFFF_FFFE, 32'd1, 1'b1);
    step();
    ex_valid = 1'b0;
    check("bge_redirect_valid", 32'(redirect_valid), 32'd1);
    check("bge_redirect_pc",    redirect_pc,         32'h0000_0110);
    check("bge_bht3",           32'(dut.bht_q[3]),   32'd0);
    check("bge_mispred_cnt",    32'(mispred_cnt),    32'd3);
    step();

    // Stalled mispredicting BEQ (index 2): no effect
    ex_stall = 1'b1;
    present(3'd1, 32'h10C, 32'd4, 32'd9, 32'd9, 1'b0);
    step();
    check("stall_redirect",    32'(redirect_valid), 32'd0);
    check("stall_branch_cnt",  32'(branch_cnt),     32'd8);
    check("stall_mispred_cnt", 32'(mispred_cnt),    32'd3);
    check("stall_bht2",        32'(dut.bht_q[2]),   32'd1);
    ex_stall = 1'b0;
    step();
    ex_valid = 1'b0;
    check("unstall_redirect_valid", 32'(redirect_valid), 32'd1);
    check("unstall_redirect_pc",    redirect_pc,         32'h0000_011C);
    check("unstall_bht2",           32'(dut.bht_q[2]),   32'd2);
    check("unstall_branch_cnt",     32'(branch_cnt),     32'd9);

    // Reset during the redirect pulse
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_redirect", 32'(redirect_valid), 32'd0);
    check("async_rst_flush",    32'(flush),          32'd0);
    check("async_rst_branch",   32'(branch_cnt),     32'd0);
    check("async_rst_bht2",     32'(dut.bht_q[2]),   32'd1);
    step();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
